// File: rtl/spi_slave_responder.sv
// spi_slave_responder: oversampled SPI slave with rx valid/ready and a one-deep tx holding register
module spi_slave_responder #(
  parameter int DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE = 8'hFF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  cspol,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  busy,
  output logic                  overrun,
  output logic                  underrun,
  input  logic                  clear_flags
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr, fill;
  logic sclk_prev, cpol_r, cpha_r, cspol_r;
  logic active, cpol_e, cpha_e, cspol_e, sclk_s, mosi_s, cs_act;
  logic lead, trail, sample_e, shift_e, start, done, load_hold;
  logic [DATA_WIDTH-1:0] tx_shift, rx_shift, hold_data, next_tx;
  logic hold_full, skip, pend;
  logic [CW-1:0] bit_cnt;
  // Synchronize the asynchronous pins; fill marks when the chains hold real pin samples
  always_ff @(posedge clock)
    if (reset) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      cs_sr <= '0;
      fill <= '0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], sclk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      cs_sr <= {cs_sr[SYNC_STAGES-2:0], cs};
      fill <= {fill[SYNC_STAGES-2:0], 1'b1};
      sclk_prev <= sclk_sr[SYNC_STAGES-1];
    end
  // Edge and event decode; mode bits are frozen while a frame is active
  always_comb begin
    active = state == S_ACTIVE;
    cpol_e = active ? cpol_r : cpol;
    cpha_e = active ? cpha_r : cpha;
    cspol_e = active ? cspol_r : cspol;
    sclk_s = sclk_sr[SYNC_STAGES-1];
    mosi_s = mosi_sr[SYNC_STAGES-1];
    cs_act = fill[SYNC_STAGES-1] && (cs_sr[SYNC_STAGES-1] == cspol_e);
    lead = (sclk_prev == cpol_e) && (sclk_s != cpol_e);
    trail = (sclk_prev != cpol_e) && (sclk_s == cpol_e);
    sample_e = active && cs_act && (cpha_e ? trail : lead);
    shift_e = active && cs_act && (cpha_e ? lead : trail);
    start = !active && cs_act;
    done = sample_e && (bit_cnt == CW'(DATA_WIDTH - 1));
    load_hold = start || (shift_e && pend);
    next_tx = hold_full ? hold_data : TX_IDLE;
    tx_ready = fill[0] && !hold_full;
  end
  // State register
  always_ff @(posedge clock)
    if (reset) state <= S_IDLE;
    else state <= state_nx;
  // Next state follows the synchronized chip select
  always_comb state_nx = cs_act ? S_ACTIVE : S_IDLE;
  // Pin-side outputs
  always_comb begin
    busy = active;
    miso_oe = active;
    miso = active && tx_shift[DATA_WIDTH-1];
  end
  // Datapath: a completed word defers its tx reload to the next shift edge, so the
  // reload replaces that shift and a frame ending on a sample edge does not underrun
  always_ff @(posedge clock)
    if (reset) begin
      cpol_r <= 1'b0;
      cpha_r <= 1'b0;
      cspol_r <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      skip <= 1'b0;
      pend <= 1'b0;
      bit_cnt <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      overrun <= 1'b0;
      underrun <= 1'b0;
    end else begin
      if (!active) begin
        cpol_r <= cpol;
        cpha_r <= cpha;
        cspol_r <= cspol;
      end
      if (clear_flags) begin
        overrun <= 1'b0;
        underrun <= 1'b0;
      end
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end
      if (start) begin
        bit_cnt <= '0;
        skip <= cpha_e;
      end
      if (load_hold) begin
        tx_shift <= next_tx;
        pend <= 1'b0;
        if (hold_full) hold_full <= 1'b0;
        else underrun <= 1'b1;
      end else if (shift_e) begin
        if (skip) skip <= 1'b0;
        else tx_shift <= tx_shift << 1;
      end
      if (sample_e) begin
        rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
        bit_cnt <= done ? '0 : bit_cnt + CW'(1);
      end
      if (done) begin
        pend <= 1'b1;
        if (rx_valid && !rx_ready) overrun <= 1'b1;
        else begin
          rx_data <= {rx_shift[DATA_WIDTH-2:0], mosi_s};
          rx_valid <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_responder.sv
// tb_spi_slave_responder: bit-banged SPI master against a word-level reference model
module tb_spi_slave_responder;
  localparam int H = 6;
  logic clock = 0, reset = 1;
  logic cpol = 0, cpha = 0, cspol = 0, sclk = 0, mosi = 0, cs = 1;
  logic miso, miso_oe, tx_ready, rx_valid, busy, overrun, underrun;
  logic [7:0] tx_data = 0, rx_data;
  logic tx_valid = 0, rx_ready = 1, clear_flags = 0;
  logic [7:0] tx_q[$], txw[$], mo_q[$], mi_q[$], rx_got[$];
  int vectors = 0, miscompares = 0, drop_cyc, nw, ql;

  spi_slave_responder dut (
    .clock(clock), .reset(reset), .cpol(cpol), .cpha(cpha), .cspol(cspol),
    .sclk(sclk), .mosi(mosi), .cs(cs), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun), .underrun(underrun), .clear_flags(clear_flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // tx producer: offers queued words one at a time whenever the holding register is empty
  initial forever begin
    @(negedge clock);
    if (tx_valid) tx_valid = 0;
    else if (!reset && tx_q.size() > 0 && tx_ready) begin
      tx_data = tx_q.pop_front();
      tx_valid = 1;
    end
  end

  // rx consumer: records every word handed over
  initial forever begin
    @(negedge clock);
    if (rx_valid && rx_ready) rx_got.push_back(rx_data);
  end

  task automatic set_mode(input logic cp, input logic ph, input logic csp);
    @(negedge clock);
    reset = 1; cpol = cp; cpha = ph; cspol = csp; sclk = cp; cs = !csp; mosi = 0;
    repeat (4) @(negedge clock);
    reset = 0;
    repeat (4) @(negedge clock);
  endtask

  task automatic pulse_clear();
    @(negedge clock) clear_flags = 1;
    @(negedge clock) clear_flags = 0;
  endtask

  task automatic xfer(input int nbits);
    logic [7:0] sh_in;
    logic mb;
    sh_in = 0;
    mi_q.delete();
    cs = cspol;
    repeat (2*H) @(negedge clock);
    for (int b = 0; b < nbits; b++) begin
      mb = mo_q[b/8][7 - b%8];
      if (!cpha) begin
        mosi = mb;
        repeat (H) @(negedge clock);
        sclk = !cpol; sh_in = {sh_in[6:0], miso};
        repeat (H) @(negedge clock);
        sclk = cpol;
      end else begin
        sclk = !cpol; mosi = mb;
        repeat (H) @(negedge clock);
        sclk = cpol; sh_in = {sh_in[6:0], miso};
        repeat (H) @(negedge clock);
      end
      if (b % 8 == 7) mi_q.push_back(sh_in);
    end
    repeat (H) @(negedge clock);
    cs = !cspol;
    drop_cyc = 99;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      if (!busy) begin
        drop_cyc = k;
        break;
      end
    end
    repeat (3*H) @(negedge clock);
  endtask

  task automatic run(input int qlen, input int nbits);
    for (int k = 0; k < qlen; k++) tx_q.push_back(txw[k]);
    repeat (6) @(negedge clock);
    rx_got.delete();
    xfer(nbits);
  endtask

  // Reference: word k carries the k-th queued word or TX_IDLE; every frame loads once at
  // CS assertion and once per word boundary followed by a shift edge (cpha=0: every word,
  // cpha=1: all but the last), so underrun means fewer queued words than loads.
  task automatic check_frame(input int n, input int q);
    for (int k = 0; k < n; k++) check("miso_word", mi_q[k], k < q ? txw[k] : 8'hFF);
    check("rx_count", rx_got.size(), n);
    for (int k = 0; k < n; k++) check("rx_word", rx_got[k], mo_q[k]);
    check("underrun", underrun, q < (cpha ? n : n + 1));
    check("overrun", overrun, 0);
    check("busy_drop", drop_cyc <= 3, 1);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_flags", {overrun, underrun}, 0);
    reset = 0;
    @(negedge clock);
    check("rst_tx_ready_rise", tx_ready, 1);

    set_mode(0, 0, 0);
    txw = '{8'hA5}; mo_q = '{8'h3C};
    run(1, 8);
    check_frame(1, 1);

    set_mode(1, 1, 0);
    txw = '{8'h12, 8'h34}; mo_q = '{8'hF0, 8'h0F};
    run(2, 16);
    check_frame(2, 2);

    set_mode(0, 0, 0);
    txw.delete(); mo_q = '{8'hC7};
    run(0, 8);
    check_frame(1, 0);
    pulse_clear();
    check("underrun_clear", underrun, 0);

    set_mode(0, 1, 1);
    rx_ready = 0;
    txw = '{8'hA1, 8'hB2}; mo_q = '{8'h11, 8'h22};
    run(2, 16);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", overrun, 1);
    @(posedge clock); #1 rx_ready = 1;
    repeat (2) @(negedge clock);
    check("ovr_valid_drop", rx_valid, 0);
    check("ovr_got", rx_got.size(), 1);
    check("ovr_got_word", rx_got[0], 8'h11);

    set_mode(0, 0, 0);
    txw = '{8'hC3}; mo_q = '{8'hA6};
    run(1, 5);
    check("abort_rx", rx_got.size(), 0);
    check("abort_valid", rx_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_oe", miso_oe, 0);
    check("abort_drop", drop_cyc <= 3, 1);
    txw = '{8'h77}; mo_q = '{8'h5A};
    run(1, 8);
    check_frame(1, 1);

    set_mode(0, 0, 0);
    mo_q = '{8'h55, 8'h33};
    tx_q.push_back(8'hAA);
    repeat (6) @(negedge clock);
    fork
      xfer(16);
      begin
        repeat (60) @(negedge clock);
        reset = 1;
        @(negedge clock);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_miso", {miso, miso_oe}, 0);
        check("mid_rst_tx_ready", tx_ready, 0);
        check("mid_rst_rx", {rx_valid, rx_data}, 0);
        check("mid_rst_flags", {overrun, underrun}, 0);
        reset = 0;
        @(negedge clock);
        check("mid_rst_tx_ready_rise", tx_ready, 1);
      end
    join
    pulse_clear();
    txw = '{8'h96}; mo_q = '{8'h69};
    run(1, 8);
    check_frame(1, 1);

    for (int f = 0; f < 8; f++) begin
      nw = $urandom_range(1, 3);
      ql = $urandom_range(0, nw);
      txw.delete(); mo_q.delete();
      for (int k = 0; k < nw; k++) begin
        txw.push_back(8'($urandom));
        mo_q.push_back(8'($urandom));
      end
      set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      run(ql, 8*nw);
      check_frame(nw, ql);
      pulse_clear();
      check("rand_flags_clear", {overrun, underrun}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
